mux2x1_rr: RTL

- Upstream-side companion of demux1x2: reads words from the two per-class FIFOs (fifo_up0 / fifo_up1) and merges them into one downstream FIFO.
- Fair round-robin arbitration between the two sources.
- Honours downstream almost-full backpressure.
- Keeps per-source forwarded-word counters for observability.

---
 rtl/mux2x1_rr_pkg.sv | 15 +
 rtl/mux2x1_rr_arb2.sv | 39 +++
 rtl/mux2x1_rr.sv | 75 +++++++
 3 files changed

// File: rtl/mux2x1_rr_pkg.sv
// Shared definitions for the two-source round-robin merger: default widths,
// source index constants and a small index-to-one-hot helper.
package mux2x1_rr_pkg;

    localparam int DATA_SIZE_DEF = 10;
    localparam int CNT_SIZE_DEF  = 8;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    function automatic logic [1:0] srcOneHot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mux2x1_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the source that did not win last
// time is granted; no grant while downstream space is not allowed or in reset.
module rr_arb2
    import mux2x1_rr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_allow,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (reset && i_allow) begin
            case (i_req)
                2'b01:   w_grant = srcOneHot(SRC0);
                2'b10:   w_grant = srcOneHot(SRC1);
                2'b11:   w_grant = srcOneHot(~r_last_grant);
                default: w_grant = 2'b00;
            endcase
        end
    end

    // Starting at SRC1 makes source 0 win the very first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= SRC1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/mux2x1_rr.sv
// Merges two source FIFOs into one downstream FIFO with fair round-robin
// arbitration, almost-full backpressure and per-source forwarded-word counters.
module mux2x1_rr
    import mux2x1_rr_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo0_empty,
    input  logic                 fifo1_empty,
    input  logic [DATA_SIZE-1:0] fifo0_data,
    input  logic [DATA_SIZE-1:0] fifo1_data,
    input  logic                 fifo_down_almostfull,
    output logic                 pop_0,
    output logic                 pop_1,
    output logic [DATA_SIZE-1:0] out,
    output logic                 push,
    output logic [CNT_SIZE-1:0]  cnt0,
    output logic [CNT_SIZE-1:0]  cnt1
);

    logic [1:0]           w_grant;
    logic                 r_rd_valid;
    logic                 r_rd_sel;
    logic [DATA_SIZE-1:0] r_out;
    logic                 r_push;
    logic [CNT_SIZE-1:0]  r_cnt0;
    logic [CNT_SIZE-1:0]  r_cnt1;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_allow (!fifo_down_almostfull),
        .i_req   ({!fifo1_empty, !fifo0_empty}),
        .o_grant (w_grant)
    );

    assign pop_0 = w_grant[0];
    assign pop_1 = w_grant[1];

    // Stage 1 remembers which FIFO was read; stage 2 captures its data, which
    // the source FIFO presents the cycle after the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_sel   <= SRC0;
            r_out      <= '0;
            r_push     <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            r_rd_valid <= |w_grant;
            if (|w_grant) begin
                r_rd_sel <= w_grant[1];
            end
            r_push <= r_rd_valid;
            if (r_rd_valid) begin
                r_out <= (r_rd_sel == SRC1) ? fifo1_data : fifo0_data;
                if (r_rd_sel == SRC1) begin
                    r_cnt1 <= r_cnt1 + 1'b1;
                end else begin
                    r_cnt0 <= r_cnt0 + 1'b1;
                end
            end
        end
    end

    assign out  = r_out;
    assign push = r_push;
    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

endmodule
